// File: rtl/int8_array_feeder_pkg.sv
// Shared types and helpers for the int8 systolic array feeder.
package int8_array_feeder_pkg;

  typedef logic [1:0] feeder_state_t;

  localparam feeder_state_t ST_IDLE   = 2'd0;
  localparam feeder_state_t ST_LOAD   = 2'd1;
  localparam feeder_state_t ST_STREAM = 2'd2;
  localparam feeder_state_t ST_FLUSH  = 2'd3;

  function automatic int row_w(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/int8_array_feeder_if.sv
// Operand-buffer side handshakes plus the west/north array-edge buses of the feeder.
interface int8_array_feeder_if #(
  parameter int N         = 4,
  parameter int inputBits = 8
);
  import int8_array_feeder_pkg::*;

  localparam int ROW_W = row_w(N, inputBits);

  logic             w_valid;
  logic             w_ready;
  logic [ROW_W-1:0] w_data;
  logic             act_valid;
  logic             act_ready;
  logic [ROW_W-1:0] act_data;
  logic             act_last;
  logic [ROW_W-1:0] c_data;
  logic [N-1:0]     c_enable;
  logic [ROW_W-1:0] a_data;
  logic [N-1:0]     a_vld;

  modport master (
    output w_valid, w_data, act_valid, act_data, act_last,
    input  w_ready, act_ready, c_data, c_enable, a_data, a_vld
  );

  modport slave (
    input  w_valid, w_data, act_valid, act_data, act_last,
    output w_ready, act_ready, c_data, c_enable, a_data, a_vld
  );

endinterface

// File: rtl/int8_array_feeder_skew_line.sv
// Fixed-depth register delay line used to skew one array row (data plus valid).
module int8_array_feeder_skew_line #(
  parameter int width = 9,
  parameter int depth = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] stage [depth];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < depth; k++) stage[k] <= '0;
    end else begin
      stage[0] <= d;
      for (int k = 1; k < depth; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[depth-1];

endmodule

// File: rtl/int8_array_feeder.sv
// Preloads stationary c operands down the column chains, then streams skewed
// activation vectors into the array rows and flushes the skew lines.
module int8_array_feeder
  import int8_array_feeder_pkg::*;
#(
  parameter int N         = 4,
  parameter int inputBits = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  int8_array_feeder_if.slave bus
);

  localparam int ROW_W = row_w(N, inputBits);
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  feeder_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             w_fire;
  logic             act_fire;
  logic [ROW_W-1:0] a_flat;
  logic [N-1:0]     vld_flat;

  assign bus.w_ready   = (state == ST_LOAD);
  assign bus.act_ready = (state == ST_STREAM);
  assign w_fire        = bus.w_valid & bus.w_ready;
  assign act_fire      = bus.act_valid & bus.act_ready;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_FLUSH) && (cnt == LAST_CNT);

  // cnt counts accepted weight beats in LOAD and elapsed cycles in FLUSH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (w_fire) begin
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= ST_STREAM;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_STREAM: begin
          if (act_fire && bus.act_last) begin
            cnt   <= '0;
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // c_data holds its last row when idle so the column chains see a stable value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.c_data   <= '0;
      bus.c_enable <= '0;
    end else begin
      bus.c_enable <= {N{w_fire}};
      if (w_fire) bus.c_data <= bus.w_data;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [inputBits:0] lane_in;
    logic [inputBits:0] lane_out;

    // idle cycles inject a zero vector so downstream MAC inputs stay neutral
    assign lane_in = act_fire ? {1'b1, bus.act_data[i*inputBits +: inputBits]} : '0;

    int8_array_feeder_skew_line #(
      .width(inputBits + 1),
      .depth(i + 1)
    ) u_skew (
      .clk (clk),
      .rst (rst),
      .d   (lane_in),
      .q   (lane_out)
    );

    assign a_flat[i*inputBits +: inputBits] = lane_out[inputBits-1:0];
    assign vld_flat[i]                      = lane_out[inputBits];
  end

  assign bus.a_data = a_flat;
  assign bus.a_vld  = vld_flat;

endmodule
